mmio_bus_ctrl: RTL and testbench

- Registered memory-mapped I/O bus controller between the CPU data port and N_SLV peripheral slaves, plus a default memory slave.
- Replaces the ad-hoc combinational address switch with a parametrised base/mask region table.
- Runs one-transaction-at-a-time through a request/strobe/ready FSM with a one-cycle read-done pop strobe.
- Has an optional watchdog timeout that reports a bus error.

---
 rtl/mmio_pkg.sv | 20 ++
 rtl/mmio_addr_decode.sv | 37 +++
 rtl/mmio_bus_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_mmio_bus_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared encodings for the MMIO bus controller.
// FSM state and op encodings plus the default watchdog limit used when
// the controller is built with MMIO_TIMEOUT_EN.
package mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mmio_addr_decode.sv
// mmio_addr_decode: combinational base/mask region match.
// Lowest matching slot wins; no match or an instruction fetch selects the
// default memory slave (index N_SLV), which receives the raw address.
module mmio_addr_decode #(
  parameter int                        ADDR_W   = 20,
  parameter int                        N_SLV    = 4,
  parameter logic [N_SLV*ADDR_W-1:0]   SLV_BASE = {N_SLV{{ADDR_W{1'b0}}}},
  parameter logic [N_SLV*ADDR_W-1:0]   SLV_MASK = {N_SLV{{ADDR_W{1'b1}}}}
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              instr,
  output logic [N_SLV:0]    sel,
  output logic [ADDR_W-1:0] offset
);

  logic found;

  // Priority match: first hit from slot 0 upward; offset wraps modulo 2^ADDR_W.
  always_comb begin
    sel    = '0;
    offset = addr;
    found  = 1'b0;
    for (int i = 0; i < N_SLV; i++) begin
      if (!instr && !found &&
          ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
           (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W]))) begin
        found  = 1'b1;
        sel[i] = 1'b1;
        offset = addr - SLV_BASE[i*ADDR_W +: ADDR_W];
      end
    end
    if (!found) begin
      sel[N_SLV] = 1'b1;
    end
  end

endmodule

// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: registered one-transaction-at-a-time MMIO bus controller.
// IDLE -> ISSUE (one-cycle strobe) -> WAIT (selected s_ready) -> RESP
// (m_ready pulse, s_read_done for reads). A request held across RESP is
// not relaunched until it has been seen low once (armed flag).
// Optional watchdog: define MMIO_TIMEOUT_EN to bound WAIT to TIMEOUT cycles
// and report m_err; otherwise WAIT is unbounded and m_err is tied low.
module mmio_bus_ctrl
  import mmio_pkg::*;
#(
  parameter int                        ADDR_W   = 20,
  parameter int                        DATA_W   = 16,
  parameter int                        N_SLV    = 4,
  parameter logic [N_SLV*ADDR_W-1:0]   SLV_BASE = {N_SLV{{ADDR_W{1'b0}}}},
  parameter logic [N_SLV*ADDR_W-1:0]   SLV_MASK = {N_SLV{{ADDR_W{1'b1}}}},
  parameter int                        TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic                        cpu_clk,
  input  logic                        cpu_rst,
  input  logic [ADDR_W-1:0]           m_addr,
  input  logic [DATA_W-1:0]           m_wdata,
  input  logic                        m_read,
  input  logic                        m_write,
  input  logic                        m_instr,
  output logic [DATA_W-1:0]           m_rdata,
  output logic                        m_ready,
  output logic                        m_busy,
  output logic                        m_err,
  output logic [ADDR_W-1:0]           s_addr,
  output logic [DATA_W-1:0]           s_wdata,
  output logic [N_SLV:0]              s_sel,
  output logic                        s_read,
  output logic                        s_write,
  output logic                        s_read_done,
  input  logic [(N_SLV+1)*DATA_W-1:0] s_rdata,
  input  logic [N_SLV:0]              s_ready
);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic                armed_q, armed_d;
  logic [DATA_W-1:0]   m_rdata_q, m_rdata_d;
  logic                m_ready_q, m_ready_d;
  logic                m_busy_q, m_busy_d;
  logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
  logic [DATA_W-1:0]   s_wdata_q, s_wdata_d;
  logic [N_SLV:0]      s_sel_q, s_sel_d;
  logic                s_read_q, s_read_d;
  logic                s_write_q, s_write_d;
  logic                s_read_done_q, s_read_done_d;

  logic [N_SLV:0]      dec_sel;
  logic [ADDR_W-1:0]   dec_offset;
  logic                req;
  logic                sel_ready;
  logic [DATA_W-1:0]   sel_rdata;

`ifdef MMIO_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                m_err_q, m_err_d;
`endif

  mmio_addr_decode #(
    .ADDR_W   (ADDR_W),
    .N_SLV    (N_SLV),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decode (
    .addr   (m_addr),
    .instr  (m_instr),
    .sel    (dec_sel),
    .offset (dec_offset)
  );

  assign req       = m_read | m_write;
  assign sel_ready = |(s_ready & s_sel_q);

  // One-hot AND-OR mux of the latched slave's read data.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i <= N_SLV; i++) begin
      sel_rdata = sel_rdata | (s_rdata[i*DATA_W +: DATA_W] & {DATA_W{s_sel_q[i]}});
    end
  end

  // Next-state and registered-output computation for the transaction FSM.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    armed_d       = armed_q | ~req;
    m_rdata_d     = m_rdata_q;
    m_ready_d     = 1'b0;
    s_addr_d      = s_addr_q;
    s_wdata_d     = s_wdata_q;
    s_sel_d       = s_sel_q;
    s_read_d      = 1'b0;
    s_write_d     = 1'b0;
    s_read_done_d = 1'b0;
`ifdef MMIO_TIMEOUT_EN
    cnt_d         = cnt_q;
    m_err_d       = m_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (armed_q && req) begin
          state_d   = ST_ISSUE;
          armed_d   = 1'b0;
          op_d      = m_write ? OP_WRITE : OP_READ;
          s_sel_d   = dec_sel;
          s_addr_d  = dec_offset;
          s_wdata_d = m_wdata;
          s_read_d  = ~m_write;
          s_write_d = m_write;
`ifdef MMIO_TIMEOUT_EN
          m_err_d   = 1'b0;
`endif
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef MMIO_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_WAIT: begin
        if (sel_ready) begin
          state_d   = ST_RESP;
          m_ready_d = 1'b1;
          if (op_q == OP_READ) begin
            m_rdata_d     = sel_rdata;
            s_read_done_d = 1'b1;
          end
        end
`ifdef MMIO_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = ST_RESP;
          m_ready_d = 1'b1;
          m_err_d   = 1'b1;
          m_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    m_busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any transaction silently.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_READ;
      armed_q       <= 1'b1;
      m_rdata_q     <= '0;
      m_ready_q     <= 1'b0;
      m_busy_q      <= 1'b0;
      s_addr_q      <= '0;
      s_wdata_q     <= '0;
      s_sel_q       <= '0;
      s_read_q      <= 1'b0;
      s_write_q     <= 1'b0;
      s_read_done_q <= 1'b0;
`ifdef MMIO_TIMEOUT_EN
      cnt_q         <= '0;
      m_err_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      armed_q       <= armed_d;
      m_rdata_q     <= m_rdata_d;
      m_ready_q     <= m_ready_d;
      m_busy_q      <= m_busy_d;
      s_addr_q      <= s_addr_d;
      s_wdata_q     <= s_wdata_d;
      s_sel_q       <= s_sel_d;
      s_read_q      <= s_read_d;
      s_write_q     <= s_write_d;
      s_read_done_q <= s_read_done_d;
`ifdef MMIO_TIMEOUT_EN
      cnt_q         <= cnt_d;
      m_err_q       <= m_err_d;
`endif
    end
  end

  assign m_rdata     = m_rdata_q;
  assign m_ready     = m_ready_q;
  assign m_busy      = m_busy_q;
  assign s_addr      = s_addr_q;
  assign s_wdata     = s_wdata_q;
  assign s_sel       = s_sel_q;
  assign s_read      = s_read_q;
  assign s_write     = s_write_q;
  assign s_read_done = s_read_done_q;
`ifdef MMIO_TIMEOUT_EN
  assign m_err       = m_err_q;
`else
  assign m_err       = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// tb_mmio_bus_ctrl: directed bench for mmio_bus_ctrl.
// Region map: slot0 0x00010/0xFFFF0, slot1 0x00004/0xFFFFC,
// slot2 0x00000/0xFFFE0, slot3 0x40000/0xF0000, slot4 default.
// The watchdog scenario is included when MMIO_TIMEOUT_EN is defined.
module tb_mmio_bus_ctrl;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int N_SLV  = 4;

  logic                        cpu_clk = 1'b0;
  logic                        cpu_rst = 1'b1;
  logic [ADDR_W-1:0]           m_addr  = '0;
  logic [DATA_W-1:0]           m_wdata = '0;
  logic                        m_read  = 1'b0;
  logic                        m_write = 1'b0;
  logic                        m_instr = 1'b0;
  logic [DATA_W-1:0]           m_rdata;
  logic                        m_ready;
  logic                        m_busy;
  logic                        m_err;
  logic [ADDR_W-1:0]           s_addr;
  logic [DATA_W-1:0]           s_wdata;
  logic [N_SLV:0]              s_sel;
  logic                        s_read;
  logic                        s_write;
  logic                        s_read_done;
  logic [(N_SLV+1)*DATA_W-1:0] s_rdata = {16'hD004, 16'hC003, 16'hB002, 16'hA55A, 16'h9000};
  logic [N_SLV:0]              s_ready = 5'b11111;

  int n_assert = 0;
  int n_fail   = 0;

  mmio_bus_ctrl #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .N_SLV    (N_SLV),
    .SLV_BASE ({20'h40000, 20'h00000, 20'h00004, 20'h00010}),
    .SLV_MASK ({20'hF0000, 20'hFFFE0, 20'hFFFFC, 20'hFFFF0}),
    .TIMEOUT  (8)
  ) dut (
    .cpu_clk     (cpu_clk),
    .cpu_rst     (cpu_rst),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_read      (m_read),
    .m_write     (m_write),
    .m_instr     (m_instr),
    .m_rdata     (m_rdata),
    .m_ready     (m_ready),
    .m_busy      (m_busy),
    .m_err       (m_err),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_sel       (s_sel),
    .s_read      (s_read),
    .s_write     (s_write),
    .s_read_done (s_read_done),
    .s_rdata     (s_rdata),
    .s_ready     (s_ready)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_busy",   m_busy, 0);
    chk("rst_ready",  m_ready, 0);
    chk("rst_err",    m_err, 0);
    chk("rst_sel",    s_sel, 0);
    chk("rst_strobe", {s_read, s_write, s_read_done}, 0);
    chk("rst_rdata",  m_rdata, 0);
    chk("rst_saddr",  s_addr, 0);
    cpu_rst = 1'b0;
    tick();

    // Read slot 1 with the request held well past completion
    s_ready = 5'b11111;
    m_addr  = 20'h00006;
    m_read  = 1'b1;
    chk("rd_c0_busy", m_busy, 0);
    tick();
    chk("rd_c1_sel",   s_sel, 5'b00010);
    chk("rd_c1_addr",  s_addr, 20'h00002);
    chk("rd_c1_read",  s_read, 1);
    chk("rd_c1_write", s_write, 0);
    chk("rd_c1_busy",  m_busy, 1);
    tick();
    chk("rd_c2_read",  s_read, 0);
    chk("rd_c2_ready", m_ready, 0);
    tick();
    chk("rd_c3_ready", m_ready, 1);
    chk("rd_c3_done",  s_read_done, 1);
    chk("rd_c3_rdata", m_rdata, 16'hA55A);
    chk("rd_c3_err",   m_err, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rd_hold_read",  s_read, 0);
      chk("rd_hold_ready", m_ready, 0);
      chk("rd_hold_busy",  m_busy, 0);
    end
    m_read = 1'b0;
    tick();
    tick();

    // Write to unmapped address -> default slave, 4 wait cycles
    s_ready = 5'b01111;
    m_addr  = 20'h20000;
    m_wdata = 16'h1234;
    m_write = 1'b1;
    tick();
    chk("wr_c1_sel",   s_sel, 5'b10000);
    chk("wr_c1_write", s_write, 1);
    chk("wr_c1_read",  s_read, 0);
    chk("wr_c1_wdata", s_wdata, 16'h1234);
    chk("wr_c1_addr",  s_addr, 20'h20000);
    tick();
    chk("wr_c2_write", s_write, 0);
    chk("wr_c2_ready", m_ready, 0);
    for (int i = 3; i <= 5; i++) begin
      tick();
      chk("wr_wait_ready", m_ready, 0);
    end
    tick();
    s_ready = 5'b11111;
    chk("wr_c6_ready", m_ready, 0);
    tick();
    chk("wr_c7_ready", m_ready, 1);
    chk("wr_c7_done",  s_read_done, 0);
    chk("wr_c7_rdata", m_rdata, 16'hA55A);
    m_write = 1'b0;
    tick();
    chk("wr_c8_ready", m_ready, 0);
    tick();

    // Overlapping regions: slot 0 wins over slot 2
    m_addr = 20'h00010;
    m_read = 1'b1;
    tick();
    chk("ov_sel",  s_sel, 5'b00001);
    chk("ov_addr", s_addr, 20'h00000);
    tick();
    tick();
    chk("ov_ready", m_ready, 1);
    chk("ov_rdata", m_rdata, 16'h9000);
    m_read = 1'b0;
    tick();
    tick();

    // Instruction fetch forces the default slave
    m_addr  = 20'h00004;
    m_instr = 1'b1;
    m_read  = 1'b1;
    tick();
    chk("if_sel",  s_sel, 5'b10000);
    chk("if_addr", s_addr, 20'h00004);
    tick();
    tick();
    chk("if_ready", m_ready, 1);
    chk("if_rdata", m_rdata, 16'hD004);
    m_read  = 1'b0;
    m_instr = 1'b0;
    tick();
    tick();

`ifdef MMIO_TIMEOUT_EN
    // Watchdog: slot 3 never ready, TIMEOUT = 8
    s_ready = 5'b10111;
    m_addr  = 20'h40000;
    m_read  = 1'b1;
    tick();
    chk("to_sel", s_sel, 5'b01000);
    for (int i = 2; i <= 9; i++) begin
      tick();
      chk("to_wait_ready", m_ready, 0);
    end
    tick();
    chk("to_ready", m_ready, 1);
    chk("to_err",   m_err, 1);
    chk("to_rdata", m_rdata, 0);
    chk("to_done",  s_read_done, 0);
    m_read  = 1'b0;
    s_ready = 5'b11111;
    tick();
    tick();
    m_read = 1'b1;
    tick();
    chk("to_next_err_c1", m_err, 0);
    tick();
    tick();
    chk("to_next_ready", m_ready, 1);
    chk("to_next_err",   m_err, 0);
    chk("to_next_rdata", m_rdata, 16'hC003);
    m_read = 1'b0;
    tick();
    tick();
`endif

    // Reset asserted during WAIT aborts silently
    s_ready = 5'b10111;
    m_addr  = 20'h40005;
    m_read  = 1'b1;
    tick();
    chk("rw_c1_sel",  s_sel, 5'b01000);
    chk("rw_c1_addr", s_addr, 20'h00005);
    tick();
    tick();
    chk("rw_c3_busy", m_busy, 1);
    cpu_rst = 1'b1;
    tick();
    chk("rw_busy",   m_busy, 0);
    chk("rw_ready",  m_ready, 0);
    chk("rw_strobe", {s_read, s_write, s_read_done}, 0);
    chk("rw_sel",    s_sel, 0);
    chk("rw_rdata",  m_rdata, 0);
    cpu_rst = 1'b0;
    m_read  = 1'b0;
    s_ready = 5'b11111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rw_idle_ready", m_ready, 0);
      chk("rw_idle_busy",  m_busy, 0);
    end
    m_read = 1'b1;
    tick();
    chk("rw_new_read", s_read, 1);
    chk("rw_new_addr", s_addr, 20'h00005);
    tick();
    tick();
    chk("rw_new_ready", m_ready, 1);
    chk("rw_new_rdata", m_rdata, 16'hC003);
    chk("rw_new_err",   m_err, 0);
    m_read = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
